// File: rtl/vga_vram_arbiter.sv
// Frame-buffer port arbiter for a 640x480 display fed from a 128x96 image.
// The display owns the phase-0 cycle of every active pixel. The single pixel
// writer gets every other cycle through a 4-phase req/ack handshake. Fetch
// counters replicate each stored pixel SCALE times horizontally and each
// stored row SCALE times vertically.
module vga_vram_arbiter #(
    parameter int SCALE  = 5,
    parameter int COLS_W = 7,
    parameter int ROW_W  = 7,
    parameter int DATA_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [11:0]               H_counter,
    input  logic                      H_pixel_disp,
    input  logic                      V_pixel_disp,
    input  logic                      wr_req,
    input  logic [COLS_W+ROW_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [COLS_W+ROW_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic [DATA_W-1:0]         pix_rgb
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [COLS_W-1:0] COL_LAST = '1;

    typedef enum logic {
        W_IDLE,
        W_DONE
    } wr_state_t;

    wr_state_t          wr_state;
    logic [SUB_W-1:0]   sub_x;
    logic [SUB_W-1:0]   sub_y;
    logic [COLS_W-1:0]  col;
    logic [ROW_W-1:0]   row;
    logic               act_q;

    logic               act;
    logic [1:0]         phase;
    logic               disp_slot;
    logic               unused_h;

    assign act       = H_pixel_disp & V_pixel_disp;
    assign phase     = H_counter[1:0];
    assign disp_slot = act & (phase == 2'd0);
    // Only the pixel phase matters here; the line position comes from the H FSM flags.
    assign unused_h  = ^H_counter[11:2];

    // Fetch counters: step the replicated column each pixel, the replicated row each line.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!reset) begin
            sub_x <= '0;
            col   <= '0;
            sub_y <= '0;
            row   <= '0;
            act_q <= 1'b0;
        end else begin
            act_q <= act;
            if (!V_pixel_disp) begin
                sub_x <= '0;
                col   <= '0;
                sub_y <= '0;
                row   <= '0;
            end else if (act_q && !act) begin
                // End of an active line: rewind the column, advance the line.
                sub_x <= '0;
                col   <= '0;
                if (sub_y == SUB_LAST) begin
                    sub_y <= '0;
                    row   <= row + 1'b1;
                end else begin
                    sub_y <= sub_y + 1'b1;
                end
            end else if (act && (phase == 2'd3)) begin
                if (sub_x == SUB_LAST) begin
                    sub_x <= '0;
                    // Hold at the last column so the final pixel cannot wrap to column 0.
                    if (col != COL_LAST) begin
                        col <= col + 1'b1;
                    end
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
        end
    end

    // Writer handshake: one RAM write per request, ack held until the request drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state <= W_IDLE;
            wr_ack   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    // The write is issued combinationally in this same cycle
                    // whenever the display does not own it.
                    if (wr_req && !disp_slot) begin
                        wr_state <= W_DONE;
                        wr_ack   <= 1'b1;
                    end
                end
                W_DONE: begin
                    if (!wr_req) begin
                        wr_state <= W_IDLE;
                        wr_ack   <= 1'b0;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                    wr_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Pixel capture: RAM data read at phase 0 is valid in phase 1; blank outside active video.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_rgb <= '0;
        end else if (!act) begin
            pix_rgb <= '0;
        end else if (phase == 2'd1) begin
            pix_rgb <= ram_rdata;
        end
    end

    // RAM port mux: display read wins its slot, otherwise a pending write goes out.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_slot) begin
            ram_en   = 1'b1;
            ram_addr = {row, col};
        end else if ((wr_state == W_IDLE) && wr_req) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: reset, blanking write, display/write
// collision, a scaled frame against a preloaded RAM image, and a sustained
// writer running across an active line.
module tb_vga_vram_arbiter;

    logic        clk;
    logic        reset;
    logic [11:0] H_counter;
    logic        H_pixel_disp;
    logic        V_pixel_disp;
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ack;
    logic        ram_en;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata = '0;
    logic [2:0]  pix_rgb;

    logic [2:0]  mem [0:16383];
    int          wr_count = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    vga_vram_arbiter #(
        .SCALE (5),
        .COLS_W(7),
        .ROW_W (7),
        .DATA_W(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .H_counter   (H_counter),
        .H_pixel_disp(H_pixel_disp),
        .V_pixel_disp(V_pixel_disp),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .pix_rgb     (pix_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM model; counts every write strobe it sees.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] = ram_wdata;
            wr_count = wr_count + 1;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            H_counter    = 12'(i);
            H_pixel_disp = 1'b0;
            next_cycle();
        end
    endtask

    // One line: 'active' cycles of active video then 'blank' cycles of blanking.
    // full=1 checks every display slot and every pixel; otherwise only pixel 0's address.
    task automatic run_line(input string tag, input int line, input int active,
                            input int blank, input bit full);
        int          row_e;
        int          p;
        logic [13:0] exp_addr;
        logic [2:0]  exp_pix;
        row_e = line / 5;
        for (int h = 0; h < active + blank; h++) begin
            H_counter    = 12'(h);
            H_pixel_disp = (h < active);
            @(negedge clk);
            if (h < active && h % 4 == 0 && (full || h == 0)) begin
                p        = h / 4;
                exp_addr = {7'(row_e), 7'(p / 5)};
                check({tag, "_addr"}, {ram_en, ram_we, ram_addr}, {2'b10, exp_addr});
            end
            if (full) begin
                if (h >= 2 && h <= active) exp_pix = 3'((row_e + ((h - 2) / 4) / 5) % 8);
                else                       exp_pix = 3'd0;
                check({tag, "_pix"}, pix_rgb, exp_pix);
            end
            next_cycle();
        end
    endtask

    // Continuous 4-phase writer aimed at rows the display never reads.
    task automatic writer(input int n);
        int lat;
        int n0;
        for (int i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_addr = {7'(100 + i / 128), 7'(i % 128)};
            wr_data = 3'(i % 8);
            n0      = wr_count;
            lat     = 0;
            do begin
                next_cycle();
                lat++;
                @(negedge clk);
            end while (!wr_ack && lat < 6);
            check("sus_ack_within2", (wr_ack === 1'b1 && lat <= 2) ? 1 : 0, 1);
            next_cycle();
            wr_req = 1'b0;
            lat    = 0;
            do begin
                @(negedge clk);
                if (!wr_ack) break;
                next_cycle();
                lat++;
            end while (lat < 4);
            check("sus_ack_release", wr_ack, 0);
            check("sus_one_write", wr_count - n0, 1);
            next_cycle();
        end
    endtask

    initial begin
        reset        = 1'b0;
        H_counter    = '0;
        H_pixel_disp = 1'b0;
        V_pixel_disp = 1'b0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 3'd0;

        // Reset held with active video and a pending request.
        V_pixel_disp = 1'b1;
        H_pixel_disp = 1'b1;
        wr_req       = 1'b1;
        wr_addr      = 14'h0203;
        wr_data      = 3'd6;
        for (int h = 0; h < 8; h++) begin
            H_counter = 12'(h);
            @(negedge clk);
            check("rst_ack", wr_ack, 0);
            check("rst_pix", pix_rgb, 0);
            next_cycle();
        end
        reset     = 1'b1;
        H_counter = 12'd8;
        @(negedge clk);
        check("rel_slot", {ram_en, ram_we, ram_addr}, {2'b10, 14'h0000});
        next_cycle();
        H_counter = 12'd9;
        @(negedge clk);
        check("rel_write", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 14'h0203, 3'd6});
        next_cycle();
        H_counter = 12'd10;
        @(negedge clk);
        check("rel_ack", wr_ack, 1);
        check("rel_no_en", ram_en, 0);
        next_cycle();
        H_counter = 12'd11;
        wr_req    = 1'b0;
        @(negedge clk);
        check("rel_ack_hold", wr_ack, 1);
        next_cycle();
        H_counter = 12'd12;
        @(negedge clk);
        check("rel_ack_drop", wr_ack, 0);
        check("rel_mem", mem[14'h0203], 6);
        next_cycle();
        V_pixel_disp = 1'b0;
        idle(4);

        // Write during blanking.
        wr_req  = 1'b1;
        wr_addr = 14'h0105;
        wr_data = 3'b101;
        begin
            int n0;
            n0 = wr_count;
            @(negedge clk);
            check("blk_write", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 14'h0105, 3'b101});
            check("blk_ack0", wr_ack, 0);
            next_cycle();
            @(negedge clk);
            check("blk_ack1", wr_ack, 1);
            check("blk_no_en", ram_en, 0);
            next_cycle();
            @(negedge clk);
            check("blk_ack2", wr_ack, 1);
            next_cycle();
            wr_req = 1'b0;
            @(negedge clk);
            check("blk_ack_hold", wr_ack, 1);
            next_cycle();
            @(negedge clk);
            check("blk_ack_drop", wr_ack, 0);
            check("blk_one_write", wr_count - n0, 1);
            check("blk_mem", mem[14'h0105], 5);
            next_cycle();
        end

        // Request rising in a display slot: read first, write in phase 1.
        V_pixel_disp = 1'b1;
        H_pixel_disp = 1'b1;
        for (int h = 0; h < 20; h++) begin
            H_counter = 12'(h);
            next_cycle();
        end
        H_counter = 12'd20;
        wr_req    = 1'b1;
        wr_addr   = 14'h0A0B;
        wr_data   = 3'd2;
        @(negedge clk);
        check("col_slot", {ram_en, ram_we, ram_addr}, {2'b10, 14'h0001});
        next_cycle();
        H_counter = 12'd21;
        @(negedge clk);
        check("col_write", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 14'h0A0B, 3'd2});
        next_cycle();
        H_counter = 12'd22;
        @(negedge clk);
        check("col_ack", wr_ack, 1);
        next_cycle();
        H_counter = 12'd23;
        wr_req    = 1'b0;
        next_cycle();
        H_counter = 12'd24;
        @(negedge clk);
        check("col_ack_drop", wr_ack, 0);
        next_cycle();
        H_pixel_disp = 1'b0;
        V_pixel_disp = 1'b0;
        idle(4);

        // Scaled frame from a preloaded image.
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++)
                mem[r * 128 + c] = 3'((r + c) % 8);

        V_pixel_disp = 1'b1;
        run_line("line0", 0, 2560, 16, 1'b1);
        fork
            run_line("line1", 1, 2560, 16, 1'b1);
            writer(500);
        join
        check("sus_mem", mem[{7'd100, 7'd5}], 5);
        for (int ln = 2; ln < 6; ln++) run_line("line_full", ln, 2560, 16, 1'b1);
        for (int ln = 6; ln < 479; ln++) run_line("line_short", ln, 4, 4, 1'b0);
        run_line("line479", 479, 2560, 16, 1'b1);

        V_pixel_disp = 1'b0;
        idle(8);
        V_pixel_disp = 1'b1;
        run_line("new_frame", 0, 4, 4, 1'b0);
        V_pixel_disp = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port synchronous frame-buffer RAM between the VGA display fetch and a single pixel writer (pattern generator or CPU port). It sits between the H/V timing FSMs and the RGB output stage. It follows the 100 MHz timing grid: 4 clocks per 25 MHz pixel, with the line counter H_counter running 0..3199. During active video, one RAM slot per pixel is reserved for the display; every other cycle is available to the writer through a 4-phase req/ack handshake. A 128x96 image is upscaled by 5 in both directions to fill 640x480.

## Interface
- SCALE, 5: pixel/line replication factor.
- COLS_W, 7: column address bits (128 columns).
- ROW_W, 7: row address bits (rows used: 0..95).
- DATA_W, 3: RGB bits per pixel.
- clk  in  1  system clock, 100 MHz; all state on rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs cleared while low.
- H_counter  in  12  horizontal cycle counter 0..3199; bits [1:0] are the pixel phase.
- H_pixel_disp  in  1  horizontal active-video flag from the H FSM.
- V_pixel_disp  in  1  vertical active-video flag from the V FSM.
- wr_req  in  1  writer request; wr_addr and wr_data are held stable while high.
- wr_addr  in  COLS_W+ROW_W  write address, {row, col}.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  write done; high from the cycle after the write until wr_req falls.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable, valid with ram_en.
- ram_addr  out  COLS_W+ROW_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe.
- pix_rgb  out  DATA_W  registered pixel to the DAC; 0 outside active video.

## Operation
- act = H_pixel_disp & V_pixel_disp; phase = H_counter[1:0]; disp_slot = act & (phase==0).
- **Display slot** (disp_slot=1):
  - ram_en=1, ram_we=0, ram_addr={row,col}.
  - The writer is blocked unconditionally; the display always wins.
- **Capture**: on the edge ending a phase-1 cycle with act=1, pix_rgb <= ram_rdata.
  - On any edge with act=0, pix_rgb <= 0.
- **Fetch counters** sub_x, col, sub_y, row:
  - At the end of each phase-3 cycle with act=1: sub_x++. When sub_x hits SCALE-1 it wraps to 0 and col++.
  - On an act falling edge while V_pixel_disp=1 (end of line): sub_x=0, col=0, sub_y++. When sub_y hits SCALE-1 it wraps to 0 and row++.
  - While V_pixel_disp=0: all four counters are 0.
  - col is never incremented past 127 within a line; row stays ≤95 for 480 active lines.
- **Write FSM**, 2 states:
  - W_IDLE:
    - If wr_req=1 and disp_slot=0: this cycle drives ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data; next state W_DONE.
    - If wr_req=1 and disp_slot=1: no write; retry next cycle.
    - If wr_req=0: idle.
  - W_DONE:
    - wr_ack=1; no RAM writes.
    - Leave for W_IDLE on the edge where wr_req=0.
- Exactly one RAM write per handshake.
- When neither display nor writer owns the cycle: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.

## Timing
- ram_* outputs are combinational from the registered FSM state, counters and inputs (single-cycle grant). wr_ack and pix_rgb are registered.
- Write latency:
  - Request in a free cycle: write in the same cycle, wr_ack high on the next cycle.
  - Request in a display slot: write 1 cycle later.
  - Worst case: 1 cycle of stall.
- Handshake minimum: wr_req high 2 cycles; back-to-back writes every ≥3 cycles.
- Display pipeline: address at phase 0, data at phase 1, pix_rgb updates at the phase-1→2 edge and holds for 4 cycles. Output lags H_counter by 2 cycles.
- During blanking (act=0), every cycle is free.
- Reset low mid-write: the write strobe is dropped, the FSM goes to W_IDLE, wr_ack=0, and the writer re-requests.
- Reset values: wr_ack=0, pix_rgb=0, state W_IDLE, all counters 0. ram_en=0 unless disp_slot or wr_req are already asserted.
- Simultaneous wr_req rise and disp_slot: the display read goes ahead and the write follows in the next cycle (phase 1).

## Test plan
- **Reset**: hold reset low with act=1 and wr_req=1 -> wr_ack=0, pix_rgb=0, FSM in W_IDLE. Release reset -> first write lands in the first non-phase-0 cycle.
- **Blanking write**: act=0, wr_req=1, wr_addr=0x0105, wr_data=3'b101 -> ram_we=1 with ram_addr=0x0105 in that cycle. wr_ack=1 from the next cycle until wr_req drops, then 0. Exactly one ram_we pulse.
- **Collision**: wr_req rises in a phase-0 cycle with act=1 -> that cycle has ram_we=0 and ram_addr={row,col}; the next cycle has ram_we=1 with wr_addr.
- **Scaling**: preload RAM[{r,c}] = (r+c)%8, run a full frame -> each value is held 20 clocks (5 pixels) on pix_rgb. Line 5 of active video shows row 1. Active pixel 0 reads address 0x0000; active pixel 639 reads col 127. Active line 479 reads row 95.
- **Blanking output**: at the act falling edge, pix_rgb=0 on the next edge. The fetch address at the first active pixel of a new frame is 0.
- **Sustained writer**: a continuous 4-phase writer across a full active line -> no display read is skipped (one ram_en with ram_we=0 every 4 cycles), and every request is acked within 2 cycles of wr_req.
